// File: rtl/sm_loader_pkg.sv
// Shared definitions for the instruction-memory loader: sync byte, FSM encoding, word size.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sm_loader_pkg;

  // Byte that opens every load frame
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Bytes per instruction word (little-endian assembly)
  localparam int WORD_BYTES = 4;

  // Loader FSM encoding; CHK is only reachable when the checksum build option is enabled
  typedef enum logic [2:0] {
    IDLE,
    NODE,
    CNT_LO,
    CNT_HI,
    DATA,
    CHK,
    DONE
  } state_t;

endpackage

// File: rtl/sm_word_assembler.sv
// Collects payload bytes little-endian into a 32-bit word and flags the completing byte.
// Latency: word_o/word_done_o are combinational on the 4th byte (earlier bytes registered).
// Backpressure: none; advances only on byte_vld_i, so stalls keep a partial word intact.
module sm_word_assembler
  import sm_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    byte_vld_i,
  input  logic [7:0]              byte_i,
  output logic [8*WORD_BYTES-1:0] word_o,
  output logic                    word_done_o
);

  localparam int               IDX_W    = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  // Only the lower bytes need storage; the top byte is taken straight from the input
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [8*(WORD_BYTES-1)-1:0]   lanes_q, lanes_d;

  assign word_done_o = byte_vld_i && (idx_q == LAST_IDX);
  assign word_o      = {byte_i, lanes_q};

  // Next byte index and lane contents: byte k lands in bits [8k+7:8k]
  always_comb begin
    idx_d   = idx_q;
    lanes_d = lanes_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (byte_vld_i) begin
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
      end else begin
        lanes_d[{idx_q, 3'b000} +: 8] = byte_i;
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Byte index and lane registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/sm_imem_loader.sv
// Parses A5/node/count/payload frames from a byte stream and writes words into a node's instruction memory.
// Latency: write strobe one cycle after the 4th byte of a word; load_done one cycle after the last frame byte.
// Backpressure: in_ready low only in the single DONE cycle; payload sustained at one byte per cycle.
// Build option: SM_IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module sm_imem_loader
  import sm_loader_pkg::*;
#(
  parameter int NODES  = 9,
  parameter int SIZE   = 128,
  parameter int NODE_W = $clog2(NODES),
  parameter int ADDR_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [NODE_W-1:0] wr_node,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [7:0]      NODE_LIM = 8'(NODES);
  // One extra address bit lets the counter park at SIZE instead of wrapping
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(SIZE);

`ifdef SM_IMEM_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = CHK;
`else
  localparam state_t POST_DATA = DONE;
`endif

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [NODE_W-1:0]   node_q, node_d;
  logic                node_ok_q, node_ok_d;
  logic [7:0]          cnt_lo_q, cnt_lo_d;
  logic [15:0]         words_left_q, words_left_d;
  logic [ADDR_W:0]     addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic [NODE_W-1:0]   wr_node_q, wr_node_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
`endif

  logic                accept;
  logic                asm_clr;
  logic                asm_vld;
  logic [31:0]         asm_word;
  logic                asm_done;

  assign accept = in_valid && in_ready_q;

  sm_word_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (asm_clr),
    .byte_vld_i  (asm_vld),
    .byte_i      (in_data),
    .word_o      (asm_word),
    .word_done_o (asm_done)
  );

  // Frame parser: next state, counters, write strobe and status flags
  always_comb begin
    state_d      = state_q;
    node_d       = node_q;
    node_ok_d    = node_ok_q;
    cnt_lo_d     = cnt_lo_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_node_d    = wr_node_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cpu_hold_d   = cpu_hold_q;
    load_err_d   = load_err_q;
    asm_clr      = 1'b0;
    asm_vld      = 1'b0;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
    chk_d        = chk_q;
`endif

    case (state_q)
      IDLE: begin
        // Anything but the sync byte is swallowed while idle
        if (accept && (in_data == SYNC_BYTE)) begin
          cpu_hold_d = 1'b1;
          load_err_d = 1'b0;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
          chk_d      = 8'h00;
`endif
          state_d    = NODE;
        end
      end
      NODE: begin
        if (accept) begin
          node_d    = in_data[NODE_W-1:0];
          node_ok_d = (in_data < NODE_LIM);
          if (in_data >= NODE_LIM) begin
            load_err_d = 1'b1;
          end
          state_d = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          cnt_lo_d = in_data;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          words_left_d = {in_data, cnt_lo_q};
          addr_d       = '0;
          asm_clr      = 1'b1;
          state_d      = ({in_data, cnt_lo_q} == 16'd0) ? POST_DATA : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          asm_vld = 1'b1;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ in_data;
`endif
          if (asm_done) begin
            // Bad node: frame is drained silently, error already flagged
            if (node_ok_q) begin
              if (addr_q < ADDR_LIM) begin
                wr_en_d   = 1'b1;
                wr_node_d = node_q;
                wr_addr_d = addr_q[ADDR_W-1:0];
                wr_data_d = asm_word;
              end else begin
                load_err_d = 1'b1;
              end
            end
            if (addr_q != ADDR_LIM) begin
              addr_d = addr_q + 1'b1;
            end
            words_left_d = words_left_q - 16'd1;
            if (words_left_q == 16'd1) begin
              state_d = POST_DATA;
            end
          end
        end
      end
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        // A bad checksum only flags; writes already issued stay in memory
        if (accept) begin
          if (in_data != chk_q) begin
            load_err_d = 1'b1;
          end
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        cpu_hold_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered so the pulse/stall coincide exactly with the DONE cycle
    load_done_d = (state_d == DONE);
    in_ready_d  = (state_d != DONE);
  end

  // State, counters and registered outputs; reset drops the load and releases the cores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      node_q       <= '0;
      node_ok_q    <= 1'b0;
      cnt_lo_q     <= '0;
      words_left_q <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_node_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      node_q       <= node_d;
      node_ok_q    <= node_ok_d;
      cnt_lo_q     <= cnt_lo_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_node_q    <= wr_node_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_node   = wr_node_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_sm_imem_loader.sv
// Scoreboard bench for sm_imem_loader: frame-level model pushes expected writes/done events, monitor pops.
// Latency: n/a.
// Backpressure: driver holds each byte until in_ready, optionally inserting idle gaps.
`timescale 1ns/1ps
module tb_sm_imem_loader;

  localparam int NODES = 9;
  localparam int SIZE  = 128;
`ifdef SM_IMEM_LOADER_CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_node;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  sm_imem_loader #(.NODES(NODES), .SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_node   (wr_node),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  node;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_wr[$];
  bit   exp_err[$];
  int   exp_span[$];
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  int   frames_sent = 0;
  int   span = 0;
  logic prev_hold = 1'b0;
  wr_t  e_wr;
  bit   e_err;
  int   e_span;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  // Monitor: writes, done pulses and cpu_hold span, all sampled on the falling edge
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_wr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_write: node %0d addr %0d data 0x%08h, no write expected", wr_node, wr_addr, wr_data);
      end else begin
        e_wr = exp_wr.pop_front();
        check("wr_node", 32'(wr_node), 32'(e_wr.node));
        check("wr_addr", 32'(wr_addr), 32'(e_wr.addr));
        check("wr_data", wr_data, e_wr.data);
      end
    end
    if (load_done) begin
      done_seen++;
      if (exp_err.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_load_done: got pulse, want none");
      end else begin
        e_err = exp_err.pop_front();
        check("load_err_at_done", 32'(load_err), 32'(e_err));
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        check("cpu_hold_in_done", 32'(cpu_hold), 32'd1);
      end
    end
    if (cpu_hold) begin
      span++;
    end else if (prev_hold) begin
      if (exp_span.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_hold: got hold span %0d, want none", span);
      end else begin
        e_span = exp_span.pop_front();
        if (e_span >= 0) check("cpu_hold_span", 32'(span), 32'(e_span));
      end
      span = 0;
    end
    prev_hold = cpu_hold;
  end

  // Drive one byte starting at a falling edge; returns at the falling edge after acceptance
  task automatic send_byte(input logic [7:0] b, input bit gapped);
    int gap;
    int tries;
    gap = gapped ? int'($urandom_range(0, 3)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    tries = 0;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) fail_note("in_ready_timeout");
    @(negedge clk);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    #1;
    while (done_seen != frames_sent && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (done_seen != frames_sent) begin
      fail_note("load_done_timeout");
    end else begin
      @(negedge clk);
      #1;
      check("cpu_hold_after_done", 32'(cpu_hold), 32'd0);
    end
  endtask

  // Frame-level reference: which words land where, and whether the frame ends in error
  task automatic run_frame(input logic [7:0] node, input int count, input bit gapped,
                           input bit fixed, input bit bad_chk);
    logic [7:0]  pl[$];
    logic [7:0]  x;
    logic [31:0] w;
    bit          err;
    pl = {};
    x  = 8'h00;
    if (fixed) begin
      pl = {8'h93, 8'h02, 8'h50, 8'h00, 8'hB3, 8'h82, 8'h52, 8'h00};
      exp_wr.push_back({8'd1, 16'd0, 32'h00500293});
      exp_wr.push_back({8'd1, 16'd1, 32'h005282B3});
    end else begin
      for (int i = 0; i < count * 4; i++) pl.push_back(8'($urandom));
      for (int i = 0; i < count; i++) begin
        w = {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]};
        if (int'(node) < NODES && i < SIZE) exp_wr.push_back({node, 16'(i), w});
      end
    end
    foreach (pl[i]) x = x ^ pl[i];
    err = (int'(node) >= NODES) || (count > SIZE) || (CHK_BYTES != 0 && bad_chk);
    exp_err.push_back(err);
    exp_span.push_back(gapped ? -1 : 4 + 4 * count + CHK_BYTES);
    send_byte(8'hA5, gapped);
    send_byte(node, gapped);
    send_byte(8'(count), gapped);
    send_byte(8'(count >> 8), gapped);
    foreach (pl[i]) send_byte(pl[i], gapped);
    if (CHK_BYTES != 0) send_byte(bad_chk ? ~x : x, gapped);
    in_valid = 1'b0;
    frames_sent++;
    wait_done();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_wr_en"},     32'(wr_en),     32'd0);
    check({tag, "_wr_node"},   32'(wr_node),   32'd0);
    check({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    check({tag, "_wr_data"},   wr_data,        32'd0);
    check({tag, "_cpu_hold"},  32'(cpu_hold),  32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"},  32'(load_err),  32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);

    // Basic load, then the same frame with random gaps
    run_frame(8'd1, 2, 1'b0, 1'b1, 1'b0);
    run_frame(8'd1, 2, 1'b1, 1'b1, 1'b0);
    run_frame(8'd1, 2, 1'b1, 1'b1, 1'b0);

    // Garbage prefix then a zero-count frame
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    run_frame(8'd3, 0, 1'b0, 1'b0, 1'b0);

    // Bad node id, then a good frame clears the error
    run_frame(8'h0C, 1, 1'b0, 1'b0, 1'b0);
    run_frame(8'd2, 1, 1'b0, 1'b0, 1'b0);

    // Address overflow: one word past the memory depth
    run_frame(8'($urandom_range(0, NODES - 1)), SIZE + 1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a word
    exp_span.push_back(-1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'd1, 1'b0);
    send_byte(8'd2, 1'b0);
    send_byte(8'd0, 1'b0);
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(8'd4, 3, 1'b0, 1'b0, 1'b0);

    // Random frames with gaps
    for (int f = 0; f < 6; f++) begin
      run_frame(8'($urandom_range(0, NODES - 1)), int'($urandom_range(1, 5)), 1'b1, 1'b0, 1'b0);
    end

`ifdef SM_IMEM_LOADER_CHECKSUM_EN
    // Checksum mismatch keeps the writes but flags the frame
    run_frame(8'd5, 2, 1'b0, 1'b0, 1'b1);
    run_frame(8'd6, 2, 1'b0, 1'b0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("pending_writes", 32'(exp_wr.size()), 32'd0);
    check("pending_done", 32'(exp_err.size()), 32'd0);
    check("pending_hold", 32'(exp_span.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
